// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI ROM responder: FSM state encoding,
// the supported opcode, the continuous-mode pattern and frame field lengths.
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] OPCODE_QUAD_READ = 8'hEB;
    localparam logic [1:0] MODE_CONT        = 2'b10;

    localparam logic [3:0] CMD_BITS     = 4'd8;
    localparam logic [3:0] ADDR_NIBBLES = 4'd6;
    localparam logic [3:0] MODE_NIBBLES = 4'd2;

endpackage

// File: rtl/spi_input_sync.sv
// Brings the asynchronous SPI pins into the clk domain and turns the
// synchronized SCK into single-cycle rise/fall pulses.
module spi_input_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       select,
    input  logic       sck,
    input  logic [3:0] data,
    output logic       select_sync,
    output logic [3:0] data_sync,
    output logic       sck_rise,
    output logic       sck_fall
);

    logic       select_meta;
    logic       sck_meta;
    logic       sck_sync;
    logic       sck_prev;
    logic [3:0] data_meta;

    // Chip select resets to inactive so releasing reset never looks like a CS fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            select_meta <= 1'b1;
            select_sync <= 1'b1;
            sck_meta    <= 1'b0;
            sck_sync    <= 1'b0;
            sck_prev    <= 1'b0;
            data_meta   <= 4'h0;
            data_sync   <= 4'h0;
        end else begin
            select_meta <= select;
            select_sync <= select_meta;
            sck_meta    <= sck;
            sck_sync    <= sck_meta;
            sck_prev    <= sck_sync;
            data_meta   <= data;
            data_sync   <= data_meta;
        end
    end

    assign sck_rise = sck_sync & ~sck_prev;
    assign sck_fall = ~sck_sync & sck_prev;

endmodule

// File: rtl/qspi_rom_responder.sv
// Device side of the cartridge QSPI link: decodes quad fast-read (EB) frames,
// including continuous-read mode, and streams bytes from a synchronous ROM port.
module qspi_rom_responder
    import qspi_pkg::*;
#(
    parameter int                   ADDR_BITS     = 24,
    parameter int                   MEM_ADDR_BITS = 12,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR     = 24'h100000,
    parameter int                   DUMMY_CYCLES  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_select,
    input  logic                     spi_clk,
    input  logic [3:0]               spi_data_in,
    output logic [3:0]               spi_data_out,
    output logic [3:0]               spi_data_oe,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic                     mem_rd,
    input  logic [7:0]               mem_data,
    output logic                     cmd_error
);

    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES);

    logic       select_s;
    logic [3:0] data_s;
    logic       sck_rise;
    logic       sck_fall;

    spi_input_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .select     (spi_select),
        .sck        (spi_clk),
        .data       (spi_data_in),
        .select_sync(select_s),
        .data_sync  (data_s),
        .sck_rise   (sck_rise),
        .sck_fall   (sck_fall)
    );

    state_t                 state;
    logic [3:0]             cnt;
    logic [7:0]             shift;
    logic [ADDR_BITS-1:0]   addr;
    logic                   cont_mode;
    logic [7:0]             byte_sr;
    logic                   low_next;
    logic                   rd_pending;

    logic [ADDR_BITS-1:0]   addr_full;
    logic [ADDR_BITS-1:0]   addr_inc;
    logic [7:0]             shift_bit;
    logic [7:0]             shift_nib;

    assign addr_full = {addr[ADDR_BITS-5:0], data_s};
    assign addr_inc  = addr + ADDR_BITS'(1);
    assign shift_bit = {shift[6:0], data_s[0]};
    assign shift_nib = {shift[3:0], data_s};

    // CS high overrides everything, including an sck edge seen in the same clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            shift        <= 8'h00;
            addr         <= '0;
            cont_mode    <= 1'b0;
            byte_sr      <= 8'h00;
            low_next     <= 1'b0;
            rd_pending   <= 1'b0;
            spi_data_out <= 4'h0;
            spi_data_oe  <= 4'h0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            cmd_error    <= 1'b0;
        end else begin
            mem_rd     <= 1'b0;
            cmd_error  <= 1'b0;
            rd_pending <= mem_rd;
            if (rd_pending) begin
                byte_sr <= mem_data;
            end
            if (select_s) begin
                state        <= ST_IDLE;
                cnt          <= 4'd0;
                low_next     <= 1'b0;
                spi_data_oe  <= 4'h0;
                spi_data_out <= 4'h0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cnt   <= 4'd0;
                        shift <= 8'h00;
                        state <= cont_mode ? ST_ADDR : ST_CMD;
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            shift <= shift_bit;
                            if (cnt == CMD_BITS - 4'd1) begin
                                cnt <= 4'd0;
                                if (shift_bit == OPCODE_QUAD_READ) begin
                                    state <= ST_ADDR;
                                end else begin
                                    state     <= ST_IGNORE;
                                    cmd_error <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            addr <= addr_full;
                            if (cnt == ADDR_NIBBLES - 4'd1) begin
                                cnt      <= 4'd0;
                                mem_rd   <= 1'b1;
                                mem_addr <= addr_full[MEM_ADDR_BITS-1:0] - BASE_ADDR[MEM_ADDR_BITS-1:0];
                                state    <= ST_MODE;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                    ST_MODE: begin
                        if (sck_rise) begin
                            shift <= shift_nib;
                            if (cnt == MODE_NIBBLES - 4'd1) begin
                                cnt       <= 4'd0;
                                cont_mode <= (shift_nib[5:4] == MODE_CONT);
                                state     <= ST_DUMMY;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sck_fall && cnt == DUMMY_LAST) begin
                            spi_data_oe  <= 4'hF;
                            spi_data_out <= byte_sr[7:4];
                            low_next     <= 1'b1;
                            state        <= ST_DATA;
                        end else if (sck_rise && cnt != DUMMY_LAST) begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        // The next byte is fetched as soon as the low nibble leaves byte_sr.
                        if (sck_fall) begin
                            if (low_next) begin
                                spi_data_out <= byte_sr[3:0];
                                addr         <= addr_inc;
                                mem_rd       <= 1'b1;
                                mem_addr     <= addr_inc[MEM_ADDR_BITS-1:0] - BASE_ADDR[MEM_ADDR_BITS-1:0];
                                low_next     <= 1'b0;
                            end else begin
                                spi_data_out <= byte_sr[7:4];
                                low_next     <= 1'b1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        spi_data_oe <= 4'h0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_rom_responder.sv
// Self-checking bench for qspi_rom_responder: a mode-0 QSPI controller model
// drives frames while a behavioural ROM/flash model predicts the returned bytes.
module tb_qspi_rom_responder;

    localparam logic [23:0] BASE = 24'h100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_select = 1'b1;
    logic        spi_clk = 1'b0;
    logic [3:0]  spi_data_in = 4'h0;
    logic [3:0]  spi_data_out;
    logic [3:0]  spi_data_oe;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 8'h00;
    logic        cmd_error;

    always #5 clk = ~clk;

    qspi_rom_responder #(
        .ADDR_BITS    (24),
        .MEM_ADDR_BITS(12),
        .BASE_ADDR    (24'h100000),
        .DUMMY_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_select  (spi_select),
        .spi_clk     (spi_clk),
        .spi_data_in (spi_data_in),
        .spi_data_out(spi_data_out),
        .spi_data_oe (spi_data_oe),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .cmd_error   (cmd_error)
    );

    logic [7:0] rom [4096];

    always @(posedge clk) begin
        if (mem_rd) mem_data <= rom[mem_addr];
    end

    int          rd_count = 0;
    int          err_count = 0;
    int          oe_active = 0;
    logic [11:0] rd_hist[$];

    // Bus monitor: records every ROM read and error pulse, away from the active edge.
    always @(negedge clk) begin
        if (mem_rd) begin
            rd_count++;
            rd_hist.push_back(mem_addr);
        end
        if (cmd_error) err_count++;
        if (spi_data_oe != 4'h0) oe_active++;
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got_bytes [8];
    int         bad_oe;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic sckCycle(input logic [3:0] nib, output logic [3:0] dout, output logic [3:0] oe);
        spi_data_in = nib;
        repeat (4) @(negedge clk);
        dout = spi_data_out;
        oe   = spi_data_oe;
        spi_clk = 1'b1;
        repeat (4) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    // One controller frame; abort_nib >= 0 raises CS after that many address nibbles.
    task automatic applyStimulus(input bit send_cmd, input logic [7:0] opcode,
                                 input logic [23:0] addr, input logic [7:0] mode,
                                 input int nbytes, input int abort_nib,
                                 input bit exp_drive, input bit release_cs);
        logic [3:0] d, o, hi;
        int n_addr;
        bad_oe = 0;
        n_addr = (abort_nib >= 0) ? abort_nib : 6;
        spi_select = 1'b0;
        repeat (4) @(negedge clk);
        if (send_cmd) begin
            for (int i = 0; i < 8; i++) begin
                sckCycle({3'b000, opcode[7-i]}, d, o);
                if (o != 4'h0) bad_oe++;
            end
        end
        for (int i = 0; i < n_addr; i++) begin
            sckCycle(addr[23-4*i -: 4], d, o);
            if (o != 4'h0) bad_oe++;
        end
        if (abort_nib < 0) begin
            sckCycle(mode[7:4], d, o);
            if (o != 4'h0) bad_oe++;
            sckCycle(mode[3:0], d, o);
            if (o != 4'h0) bad_oe++;
            for (int i = 0; i < 4; i++) begin
                sckCycle($urandom_range(0, 15), d, o);
                if (o != 4'h0) bad_oe++;
            end
            for (int b = 0; b < nbytes; b++) begin
                sckCycle(4'h0, hi, o);
                if (o != (exp_drive ? 4'hF : 4'h0)) bad_oe++;
                sckCycle(4'h0, d, o);
                if (o != (exp_drive ? 4'hF : 4'h0)) bad_oe++;
                got_bytes[b] = {hi, d};
            end
        end
        repeat (4) @(negedge clk);
        if (release_cs) begin
            spi_select = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    function automatic int romIndex(input logic [23:0] addr, input int k);
        int x;
        x = int'(addr) - int'(BASE) + k;
        return ((x % 4096) + 4096) % 4096;
    endfunction

    typedef struct {
        bit          send_cmd;
        logic [7:0]  opcode;
        logic [23:0] addr;
        logic [7:0]  mode;
        int          nbytes;
        int          exp_err;
        int          exp_rd;
        int          exp_maddr;
        logic [31:0] exp_bytes;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int rd0, err0, oe0;
        bit model_cont;
        logic [23:0] raddr;
        logic [7:0]  rmode;
        int          rn;
        bit          rcmd;

        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[12'h010] = 8'hA5;
        rom[12'h011] = 8'h3C;
        rom[12'h012] = 8'h0F;
        rom[12'h013] = 8'hF0;
        rom[12'h020] = 8'h5A;
        rom[12'hFFF] = 8'hC3;
        rom[12'h000] = 8'h7E;

        vecs[0] = '{1'b1, 8'hEB, 24'h100010, 8'h00, 4, 0, 5, 12'h010, 32'hA53C0FF0};
        vecs[1] = '{1'b1, 8'hEB, 24'h100020, 8'h00, 1, 0, 2, 12'h020, 32'h5A000000};
        vecs[2] = '{1'b1, 8'h03, 24'h100010, 8'h00, 2, 1, 0, 12'h000, 32'h00000000};
        vecs[3] = '{1'b1, 8'hEB, 24'h0FFFFF, 8'h00, 2, 0, 3, 12'hFFF, 32'hC37E0000};

        // Reset held with CS low and SCK toggling: nothing may respond.
        rd0 = rd_count; err0 = err_count; oe0 = oe_active;
        spi_select = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [3:0] d, o;
            sckCycle(4'($urandom), d, o);
        end
        checkOutput("reset_oe_activity", oe_active - oe0, 0);
        checkOutput("reset_mem_rd", rd_count - rd0, 0);
        checkOutput("reset_cmd_error", err_count - err0, 0);
        checkOutput("reset_data_out", spi_data_out, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        spi_select = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            rd0 = rd_count; err0 = err_count;
            applyStimulus(vecs[v].send_cmd, vecs[v].opcode, vecs[v].addr, vecs[v].mode,
                          vecs[v].nbytes, -1, vecs[v].exp_err == 0, 1'b1);
            checkOutput($sformatf("vec%0d_cmd_error", v), err_count - err0, vecs[v].exp_err);
            checkOutput($sformatf("vec%0d_rd_count", v), rd_count - rd0, vecs[v].exp_rd);
            checkOutput($sformatf("vec%0d_oe", v), bad_oe, 0);
            checkOutput($sformatf("vec%0d_oe_after_cs", v), spi_data_oe, 0);
            if (vecs[v].exp_err == 0) begin
                for (int b = 0; b < vecs[v].nbytes; b++) begin
                    checkOutput($sformatf("vec%0d_byte%0d", v, b), got_bytes[b],
                                int'(vecs[v].exp_bytes[31-8*b -: 8]));
                    checkOutput($sformatf("vec%0d_maddr%0d", v, b), rd_hist[rd0 + b],
                                (vecs[v].exp_maddr + b) % 4096);
                end
            end
        end

        // Continuous mode: A0 arms it, next frame starts at the address with wrap.
        rom[12'h040] = 8'($urandom);
        applyStimulus(1'b1, 8'hEB, 24'h100040, 8'hA0, 1, -1, 1'b1, 1'b1);
        checkOutput("cont_arm_byte", got_bytes[0], rom[12'h040]);
        rd0 = rd_count;
        applyStimulus(1'b0, 8'h00, 24'h100FFF, 8'h00, 2, -1, 1'b1, 1'b1);
        checkOutput("cont_byte0", got_bytes[0], 8'hC3);
        checkOutput("cont_byte1", got_bytes[1], 8'h7E);
        checkOutput("cont_maddr0", rd_hist[rd0], 12'hFFF);
        checkOutput("cont_maddr1", rd_hist[rd0 + 1], 12'h000);
        applyStimulus(1'b1, 8'hEB, 24'h100010, 8'h00, 1, -1, 1'b1, 1'b1);
        checkOutput("cont_cleared_byte", got_bytes[0], 8'hA5);

        // Aborted address phase leaves no ROM read and no residue.
        rd0 = rd_count;
        applyStimulus(1'b1, 8'hEB, 24'h100055, 8'h00, 0, 3, 1'b0, 1'b1);
        checkOutput("abort_rd_count", rd_count - rd0, 0);
        checkOutput("abort_oe", bad_oe, 0);
        rd0 = rd_count;
        applyStimulus(1'b1, 8'hEB, 24'h100020, 8'h00, 1, -1, 1'b1, 1'b1);
        checkOutput("post_abort_byte", got_bytes[0], 8'h5A);
        checkOutput("post_abort_maddr", rd_hist[rd0], 12'h020);

        // Reset in the middle of DATA with continuous mode armed.
        applyStimulus(1'b1, 8'hEB, 24'h100010, 8'hA0, 1, -1, 1'b1, 1'b0);
        checkOutput("mid_data_byte", got_bytes[0], 8'hA5);
        checkOutput("mid_data_oe", spi_data_oe, 4'hF);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_oe", spi_data_oe, 0);
        checkOutput("async_reset_mem_rd", mem_rd, 0);
        spi_select = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(1'b1, 8'hEB, 24'h100013, 8'h00, 1, -1, 1'b1, 1'b1);
        checkOutput("post_reset_cmd_byte", got_bytes[0], 8'hF0);

        // Randomized frames against the flash model, tracking continuous mode.
        model_cont = 1'b0;
        for (int t = 0; t < 10; t++) begin
            raddr = 24'($urandom);
            rmode = 8'($urandom);
            rn    = $urandom_range(1, 4);
            rcmd  = !model_cont;
            rd0 = rd_count; err0 = err_count;
            applyStimulus(rcmd, 8'hEB, raddr, rmode, rn, -1, 1'b1, 1'b1);
            checkOutput($sformatf("rand%0d_rd_count", t), rd_count - rd0, rn + 1);
            checkOutput($sformatf("rand%0d_oe", t), bad_oe, 0);
            for (int b = 0; b < rn; b++) begin
                checkOutput($sformatf("rand%0d_byte%0d", t, b), got_bytes[b], rom[romIndex(raddr, b)]);
            end
            model_cont = (rmode[5:4] == 2'b10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
